// File: rtl/fpu_dp_pkg.sv
// rtl/fpu_dp_pkg.sv - shared types, constants and round/pack helper for the binary64 unit
// Contents: opcode enum, field widths, special-value constants, result struct,
//           round_pack() which rounds a normalized 56-bit mantissa (RNE) and packs it.
package fpu_dp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int BIAS   = 1023;

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NEG_INF = 64'hFFF0_0000_0000_0000;

  typedef struct packed {
    logic [63:0] bits;
    logic        ovf;
    logic        udf;
  } fpu_res_t;

  // mant layout: [55] hidden one, [54:3] fraction, [2] guard, [1] round, [0] sticky.
  // exp_in is the biased exponent belonging to mant[55]; it may be out of range.
  function automatic fpu_res_t round_pack(input logic               sgn,
                                          input logic signed [13:0] exp_in,
                                          input logic [55:0]        mant);
    fpu_res_t           res;
    logic               up;
    logic [53:0]        rnd;
    logic [51:0]        frac;
    logic signed [13:0] e;
    up   = mant[2] & (mant[1] | mant[0] | mant[3]);
    rnd  = {1'b0, mant[55:3]} + 54'(up);
    // a carry out of rounding renormalizes by one bit and bumps the exponent
    frac = rnd[53] ? rnd[52:1] : rnd[51:0];
    e    = rnd[53] ? exp_in + 14'sd1 : exp_in;
    res  = '0;
    if (e >= 14'sd2047) begin
      res.bits = sgn ? NEG_INF : POS_INF;
      res.ovf  = 1'b1;
    end else if (e <= 14'sd0) begin
      res.bits = {sgn, 63'd0};
      res.udf  = 1'b1;
    end else begin
      res.bits = {sgn, e[EXP_W-1:0], frac};
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_dp_mant_div.sv
// rtl/fpu_dp_mant_div.sv - combinational restoring divider for 53-bit mantissas
// Ports: i_dividend, i_divisor - 53-bit mantissas with hidden one set;
//        o_quotient - floor(dividend * 2^56 / divisor), leading one at bit 56 or 55;
//        o_sticky   - nonzero remainder.
module fpu_dp_mant_div
  import fpu_dp_pkg::*;
(
  input  logic [FRAC_W:0]   i_dividend,
  input  logic [FRAC_W:0]   i_divisor,
  output logic [56:0]       o_quotient,
  output logic              o_sticky
);

  logic [FRAC_W+1:0] w_rem;

  // Both inputs lie in [2^52, 2^53), so the partial remainder stays below
  // twice the divisor and fits in 54 bits across every step.
  always_comb begin
    w_rem      = {1'b0, i_dividend};
    o_quotient = '0;
    for (int i = 56; i >= 0; i--) begin
      if (w_rem >= {1'b0, i_divisor}) begin
        o_quotient[i] = 1'b1;
        w_rem         = w_rem - {1'b0, i_divisor};
      end
      w_rem = w_rem << 1;
    end
    o_sticky = (w_rem != '0);
  end

endmodule

// File: rtl/fpu_dp_unit.sv
// rtl/fpu_dp_unit.sv - two-stage binary64 add/sub/mul/div pipeline with status flags
// Ports: clk, rst_n (asynchronous, active low); A, B binary64 operands;
//        opCode 00 add, 01 sub, 10 mul, 11 div; result binary64;
//        Ready pipeline primed; Overflow / Underflow status of result.
module fpu_dp_unit
  import fpu_dp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [1:0]  opCode,
  output logic [63:0] result,
  output logic        Ready,
  output logic        Overflow,
  output logic        Underflow
);

  logic [63:0] r_a, r_b, r_result;
  fpu_op_e     r_op;
  logic [1:0]  r_valid;
  logic        r_ovf, r_udf;

  logic              w_sa, w_sb, w_sbe, w_smd;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W:0]   w_ma, w_mb;
  logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;

  assign w_sa  = r_a[63];
  assign w_sb  = r_b[63];
  assign w_sbe = r_b[63] ^ (r_op == OP_SUB);
  assign w_smd = w_sa ^ w_sb;
  assign w_ea  = r_a[62:FRAC_W];
  assign w_eb  = r_b[62:FRAC_W];
  assign w_ma  = {1'b1, r_a[FRAC_W-1:0]};
  assign w_mb  = {1'b1, r_b[FRAC_W-1:0]};
  // exponent field 0 covers subnormals too: they are treated as zero
  assign w_za  = (w_ea == '0);
  assign w_zb  = (w_eb == '0);
  assign w_ia  = (w_ea == '1) && (r_a[FRAC_W-1:0] == '0);
  assign w_ib  = (w_eb == '1) && (r_b[FRAC_W-1:0] == '0);
  assign w_na  = (w_ea == '1) && (r_a[FRAC_W-1:0] != '0);
  assign w_nb  = (w_eb == '1) && (r_b[FRAC_W-1:0] != '0);

  // ---- add / subtract ----
  logic               w_swap, w_sbig, w_sticky;
  logic [EXP_W-1:0]   w_ebig, w_esml, w_d;
  logic [55:0]        w_big, w_sml, w_shift, w_align, w_add_m;
  logic [56:0]        w_sum;
  logic [5:0]         w_lz;
  logic signed [13:0] w_add_e;

  // magnitude compare on the exponent:fraction field picks the larger operand,
  // so the effective subtraction never goes negative
  assign w_swap   = r_b[62:0] > r_a[62:0];
  assign w_sbig   = w_swap ? w_sbe : w_sa;
  assign w_ebig   = w_swap ? w_eb : w_ea;
  assign w_esml   = w_swap ? w_ea : w_eb;
  assign w_big    = {(w_swap ? w_mb : w_ma), 3'b000};
  assign w_sml    = {(w_swap ? w_ma : w_mb), 3'b000};
  assign w_d      = w_ebig - w_esml;
  assign w_shift  = w_sml >> w_d;
  assign w_sticky = (w_shift << w_d) != w_sml;
  assign w_align  = {w_shift[55:1], w_shift[0] | w_sticky};
  assign w_sum    = (w_sa ^ w_sbe) ? ({1'b0, w_big} - {1'b0, w_align})
                                   : ({1'b0, w_big} + {1'b0, w_align});

  always_comb begin
    w_lz = 6'd0;
    for (int i = 0; i < 56; i++) begin
      if (w_sum[i]) w_lz = 6'(55 - i);
    end
  end

  always_comb begin
    if (w_sum[56]) begin
      w_add_m = {w_sum[56:2], w_sum[1] | w_sum[0]};
      w_add_e = $signed({3'b000, w_ebig}) + 14'sd1;
    end else begin
      w_add_m = w_sum[55:0] << w_lz;
      w_add_e = $signed({3'b000, w_ebig}) - $signed({8'd0, w_lz});
    end
  end

  // ---- multiply ----
  logic [105:0]       w_prod;
  logic [55:0]        w_mul_m;
  logic signed [13:0] w_mul_e;

  assign w_prod  = {53'd0, w_ma} * {53'd0, w_mb};
  assign w_mul_m = w_prod[105] ? {w_prod[105:51], |w_prod[50:0]}
                               : {w_prod[104:50], |w_prod[49:0]};
  assign w_mul_e = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 14'(BIAS)
                 + (w_prod[105] ? 14'sd1 : 14'sd0);

  // ---- divide ----
  logic [56:0]        w_quo;
  logic               w_qst;
  logic [55:0]        w_div_m;
  logic signed [13:0] w_div_e;

  fpu_dp_mant_div u_mant_div (
    .i_dividend (w_ma),
    .i_divisor  (w_mb),
    .o_quotient (w_quo),
    .o_sticky   (w_qst)
  );

  assign w_div_m = w_quo[56] ? {w_quo[56:2], w_quo[1] | w_quo[0] | w_qst}
                             : {w_quo[55:1], w_quo[0] | w_qst};
  assign w_div_e = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 14'(BIAS)
                 - (w_quo[56] ? 14'sd0 : 14'sd1);

  // ---- special cases and result select ----
  fpu_res_t w_res;

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sbe))) w_res.bits = QNAN;
        else if (w_ia)             w_res.bits = w_sa ? NEG_INF : POS_INF;
        else if (w_ib)             w_res.bits = w_sbe ? NEG_INF : POS_INF;
        else if (w_za && w_zb)     w_res.bits = {w_sa & w_sbe, 63'd0};
        else if (w_za)             w_res.bits = {w_sbe, r_b[62:0]};
        else if (w_zb)             w_res.bits = r_a;
        else if (w_sum == '0)      w_res.bits = 64'd0;  // exact cancellation
        else                       w_res = round_pack(w_sbig, w_add_e, w_add_m);
      end
      OP_MUL: begin
        if (w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib)) w_res.bits = QNAN;
        else if (w_ia || w_ib)     w_res.bits = w_smd ? NEG_INF : POS_INF;
        else if (w_za || w_zb)     w_res.bits = {w_smd, 63'd0};
        else                       w_res = round_pack(w_smd, w_mul_e, w_mul_m);
      end
      default: begin
        if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) w_res.bits = QNAN;
        else if (w_ia)             w_res.bits = w_smd ? NEG_INF : POS_INF;
        else if (w_ib)             w_res.bits = {w_smd, 63'd0};
        else if (w_zb) begin
          w_res.bits = w_smd ? NEG_INF : POS_INF;
          w_res.ovf  = 1'b1;
        end
        else if (w_za)             w_res.bits = {w_smd, 63'd0};
        else                       w_res = round_pack(w_smd, w_div_e, w_div_m);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_valid  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_a      <= A;
      r_b      <= B;
      r_op     <= fpu_op_e'(opCode);
      r_valid  <= {r_valid[0], 1'b1};
      r_result <= w_res.bits;
      r_ovf    <= w_res.ovf;
      r_udf    <= w_res.udf;
    end
  end

  assign result    = r_result;
  assign Ready     = r_valid[1];
  assign Overflow  = r_ovf;
  assign Underflow = r_udf;

endmodule

// File: tb/tb_fpu_dp_unit.sv
// tb/tb_fpu_dp_unit.sv - directed and random checks of fpu_dp_unit against host real arithmetic
module tb_fpu_dp_unit;
  import fpu_dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [1:0]  opCode = 2'b00;
  logic [63:0] result;
  logic        Ready, Overflow, Underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_dp_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .opCode    (opCode),
    .result    (result),
    .Ready     (Ready),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  function automatic logic [63:0] ref_bits(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] op);
    real x, y, z;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (op)
      2'd0:    z = x + y;
      2'd1:    z = x - y;
      2'd2:    z = x * y;
      default: z = x / y;
    endcase
    return $realtobits(z);
  endfunction

  function automatic logic [63:0] rand_normal();
    return {1'($urandom_range(0, 1)), 11'($urandom_range(823, 1223)),
            20'($urandom), 32'($urandom)};
  endfunction

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic [63:0] er,
                        input logic eo, input logic eu);
    @(negedge clk);
    A = a; B = b; opCode = op;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, " result"}, result, er);
    check_eq({tag, " ovf"}, {63'd0, Overflow}, {63'd0, eo});
    check_eq({tag, " udf"}, {63'd0, Underflow}, {63'd0, eu});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sa[4], sb[4], se[4];
    logic [1:0]  so[4];
    logic [63:0] q_exp[$];
    logic [63:0] ra, rb, one, tiny;
    logic [1:0]  rop;

    // reset held with 4.2 + 3.2 applied
    A = $realtobits(4.2); B = $realtobits(3.2); opCode = 2'b00;
    @(negedge clk);
    check_eq("reset ready", {63'd0, Ready}, 64'd0);
    check_eq("reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready after 1 edge", {63'd0, Ready}, 64'd0);
    @(negedge clk);
    check_eq("first result 7.4", result, $realtobits(7.4));
    check_eq("first result model", result, ref_bits($realtobits(4.2), $realtobits(3.2), 2'b00));
    check_eq("ready after 2 edges", {63'd0, Ready}, 64'd1);

    // back-to-back stream, one op per cycle
    sa[0] = $realtobits(-0.0132); sb[0] = $realtobits(-1235.3412); so[0] = 2'b00;
    sa[1] = $realtobits(-6.4);    sb[1] = $realtobits(-0.5);       so[1] = 2'b01;
    sa[2] = $realtobits(123.0);   sb[2] = $realtobits(412.0);      so[2] = 2'b10;
    sa[3] = $realtobits(4.2);     sb[3] = $realtobits(3.2);        so[3] = 2'b11;
    for (int k = 0; k < 4; k++) se[k] = ref_bits(sa[k], sb[k], so[k]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) check_eq($sformatf("stream op%0d", k - 2), result, se[k - 2]);
      if (k < 4) begin
        A = sa[k]; B = sb[k]; opCode = so[k];
      end
    end
    check_eq("mul exact 50676", se[2], $realtobits(50676.0));

    // overflow / underflow / divide by zero
    run_op("1e308*10", $realtobits(1.0e308), $realtobits(10.0), 2'b10, POS_INF, 1'b1, 1'b0);
    run_op("1e-300*1e-100", $realtobits(1.0e-300), $realtobits(1.0e-100), 2'b10, 64'd0, 1'b0, 1'b1);
    run_op("max+max", 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 2'b00, POS_INF, 1'b1, 1'b0);
    run_op("1/0", $realtobits(1.0), 64'd0, 2'b11, POS_INF, 1'b1, 1'b0);

    // reset mid-stream: outputs clear without waiting for a clock edge
    @(negedge clk);
    A = $realtobits(7.0); B = $realtobits(2.0); opCode = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset result", result, 64'd0);
    check_eq("midreset ovf", {63'd0, Overflow}, 64'd0);
    check_eq("midreset ready", {63'd0, Ready}, 64'd0);
    @(negedge clk);
    A = $realtobits(2.0); B = $realtobits(3.0); opCode = 2'b10;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post-reset ready 1 edge", {63'd0, Ready}, 64'd0);
    @(negedge clk);
    check_eq("post-reset result", result, $realtobits(6.0));
    check_eq("post-reset ready 2 edges", {63'd0, Ready}, 64'd1);

    // specials
    run_op("nan+1", 64'h7FF0_0000_0000_0001, $realtobits(1.0), 2'b00, QNAN, 1'b0, 1'b0);
    run_op("inf-inf", POS_INF, POS_INF, 2'b01, QNAN, 1'b0, 1'b0);
    run_op("0*-5", 64'd0, $realtobits(-5.0), 2'b10, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    run_op("5-5", $realtobits(5.0), $realtobits(5.0), 2'b01, 64'd0, 1'b0, 1'b0);
    run_op("0/0", 64'd0, 64'd0, 2'b11, QNAN, 1'b0, 1'b0);
    run_op("inf*-2", POS_INF, $realtobits(-2.0), 2'b10, NEG_INF, 1'b0, 1'b0);

    // rounding ties around 1.0
    one  = $realtobits(1.0);
    tiny = 64'h3CA0_0000_0000_0000;
    run_op("1+2^-53 tie even", one, tiny, 2'b00, one, 1'b0, 1'b0);
    run_op("1+2^-53+ulp up", one, 64'h3CA0_0000_0000_0001, 2'b00,
           ref_bits(one, 64'h3CA0_0000_0000_0001, 2'b00), 1'b0, 1'b0);
    run_op("1-2^-54", one, 64'h3C90_0000_0000_0000, 2'b01,
           ref_bits(one, 64'h3C90_0000_0000_0000, 2'b01), 1'b0, 1'b0);

    // random normal operands, streamed one per cycle
    for (int k = 0; k < 10002; k++) begin
      @(negedge clk);
      if (k >= 2) check_eq($sformatf("rand %0d", k - 2), result, q_exp.pop_front());
      if (k < 10000) begin
        ra = rand_normal();
        rb = rand_normal();
        rop = 2'($urandom_range(0, 3));
        A = ra; B = rb; opCode = rop;
        q_exp.push_back(ref_bits(ra, rb, rop));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
